// File: rtl/cvt_issue_arbiter.sv
// Round-robin front end that shares one SP_Convert datapath between NUM_REQ requesters,
// with an issue register (S1), a response register (S2) and a sticky exception-flag accumulator.
module cvt_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_operand,
    input  logic [NUM_REQ*2-1:0]     req_in_type,
    input  logic [NUM_REQ*2-1:0]     req_out_type,
    input  logic [NUM_REQ*3-1:0]     req_rm,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [31:0]              cvt_operand,
    output logic [1:0]               cvt_in_type,
    output logic [1:0]               cvt_out_type,
    output logic [2:0]               cvt_rm,
    input  logic [63:0]              cvt_result,
    input  logic [3:0]               cvt_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [63:0]              rsp_result,
    output logic [3:0]               rsp_flags,
    output logic [3:0]               fflags_acc,
    input  logic                     fflags_clr,
    output logic                     busy
);

    logic              s1_valid;
    logic [31:0]       s1_operand;
    logic [1:0]        s1_in_type;
    logic [1:0]        s1_out_type;
    logic [2:0]        s1_rm;
    logic [TAG_W-1:0]  s1_tag;
    logic [ID_W-1:0]   s1_id;
    logic              s1_illegal;

    logic              s2_valid;
    logic [ID_W-1:0]   s2_id;
    logic [TAG_W-1:0]  s2_tag;
    logic [63:0]       s2_result;
    logic [3:0]        s2_flags;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    int                grant_idx;
    logic              grant_found;

    logic              s2_free;
    logic              s1_adv;
    logic              can_acc;
    logic              accept;
    logic              rsp_hs;

    logic [31:0]       g_operand;
    logic [1:0]        g_in_type;
    logic [1:0]        g_out_type;
    logic [2:0]        g_rm;
    logic [TAG_W-1:0]  g_tag;

    function automatic logic op_illegal(input logic [1:0] in_type,
                                        input logic [1:0] out_type,
                                        input logic [2:0] rm);
        op_illegal = (in_type == 2'b01)
                   | ((in_type == 2'b00) && (out_type == 2'b00))
                   | (in_type[1] && (out_type != 2'b01))
                   | (rm > 3'b100);
    endfunction

    assign s2_free = !s2_valid || rsp_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign can_acc = !s1_valid || s1_adv;
    assign rsp_hs  = s2_valid && rsp_ready;

    // Scan from rr_ptr upward with wraparound; first asserted valid wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = 0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant       = ID_W'(idx);
                grant_idx   = idx;
                grant_found = 1'b1;
            end
        end
    end

    // rst_n gating keeps req_ready low while the block is held in reset.
    assign accept = grant_found && can_acc && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign g_operand  = req_operand[grant_idx*32 +: 32];
    assign g_in_type  = req_in_type[grant_idx*2 +: 2];
    assign g_out_type = req_out_type[grant_idx*2 +: 2];
    assign g_rm       = req_rm[grant_idx*3 +: 3];
    assign g_tag      = req_tag[grant_idx*TAG_W +: TAG_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_operand  <= '0;
            s1_in_type  <= '0;
            s1_out_type <= '0;
            s1_rm       <= '0;
            s1_tag      <= '0;
            s1_id       <= '0;
            s1_illegal  <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            if (accept) begin
                s1_valid    <= 1'b1;
                s1_operand  <= g_operand;
                s1_in_type  <= g_in_type;
                s1_out_type <= g_out_type;
                s1_rm       <= g_rm;
                s1_tag      <= g_tag;
                s1_id       <= grant;
                s1_illegal  <= op_illegal(g_in_type, g_out_type, g_rm);
                rr_ptr      <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Illegal ops never use the converter output; they complete as NV with a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_id     <= '0;
            s2_tag    <= '0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else begin
            if (s1_adv) begin
                s2_valid  <= 1'b1;
                s2_id     <= s1_id;
                s2_tag    <= s1_tag;
                s2_result <= s1_illegal ? 64'd0 : cvt_result;
                s2_flags  <= s1_illegal ? 4'b1000 : cvt_flags;
            end else if (rsp_hs) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_acc <= '0;
        end else begin
            fflags_acc <= (fflags_clr ? 4'b0000 : fflags_acc) | (rsp_hs ? s2_flags : 4'b0000);
        end
    end

    assign cvt_operand  = s1_operand;
    assign cvt_in_type  = s1_in_type;
    assign cvt_out_type = s1_out_type;
    assign cvt_rm       = s1_rm;

    assign rsp_valid  = s2_valid;
    assign rsp_id     = s2_id;
    assign rsp_tag    = s2_tag;
    assign rsp_result = s2_result;
    assign rsp_flags  = s2_flags;
    assign busy       = s1_valid || s2_valid;

endmodule
